// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: assembles B/A operand packets from a word stream and sequences MAC issues
module mac_operand_sequencer #(
  parameter int MIN_WIDTH  = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int CONF_WIDTH = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [1:0]                      mode,
  input  logic                            acc_sel,
  input  logic [ACC_WIDTH-1:0]            init_val,
  input  logic [CNT_WIDTH-1:0]            op_count,
  input  logic                            in_valid,
  input  logic [MIN_WIDTH-1:0]            in_data,
  output logic                            in_ready,
  output logic                            mac_en,
  output logic [MIN_WIDTH-1:0]            mac_B1,
  output logic [MIN_WIDTH-1:0]            mac_A0,
  output logic [MIN_WIDTH-1:0]            mac_A1,
  output logic [MIN_WIDTH-1:0]            mac_A2,
  output logic [MIN_WIDTH-1:0]            mac_A3,
  output logic [ACC_WIDTH+CONF_WIDTH-1:0] mac_cfg,
  output logic                            res_valid,
  output logic                            res_last,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);
  typedef enum logic [1:0] {IDLE, LOAD_B, LOAD_A, ISSUE} state_t;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [1:0]           idx;
  logic [MIN_WIDTH-1:0] a [4];
  logic [1:0]           mode_r;
  logic                 xfer, last_a, final_op;
  assign mode_r   = mac_cfg[1:0];
  assign in_ready = state == LOAD_B || state == LOAD_A;
  assign busy     = state != IDLE;
  assign mac_en   = state == ISSUE;
  assign xfer     = in_valid && in_ready;
  assign final_op = cnt == CNT_WIDTH'(1);
  assign last_a   = mode_r == 2'b00 || (mode_r == 2'b01 ? idx == 2'd1 : idx == 2'd3);
  // Operands outside the current width mode read as zero even if stale data sits in them
  assign mac_A0   = mode_r == 2'b00 ? '0 : a[0];
  assign mac_A1   = a[1];
  assign mac_A2   = mode_r[1] ? a[2] : '0;
  assign mac_A3   = mode_r[1] ? a[3] : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      mac_B1    <= '0;
      mac_cfg   <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < 4; i++) a[i] <= '0;
    end else begin
      err       <= 1'b0;
      done      <= 1'b0;
      res_valid <= mac_en;
      res_last  <= mac_en && final_op;
      case (state)
        IDLE: if (start) begin
          if (mode == 2'b11) err <= 1'b1;
          else begin
            mac_cfg <= {init_val, acc_sel, mode};
            if (op_count == '0) done <= 1'b1;
            else begin
              cnt   <= op_count;
              state <= LOAD_B;
            end
          end
        end
        LOAD_B: if (xfer) begin
          mac_B1 <= in_data;
          idx    <= '0;
          state  <= LOAD_A;
        end
        LOAD_A: if (xfer) begin
          a[mode_r == 2'b00 ? 2'd1 : idx] <= in_data;
          idx <= idx + 2'd1;
          if (last_a) state <= ISSUE;
        end
        ISSUE: begin
          cnt   <= cnt - CNT_WIDTH'(1);
          state <= final_op ? IDLE : LOAD_B;
          if (final_op) done <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: directed vector table plus hand-built multi-cycle sequences
module tb_mac_operand_sequencer;
  logic        clk = 0, rst = 0, start = 0, acc_sel = 0, in_valid = 0;
  logic [1:0]  mode = 0;
  logic [31:0] init_val = 0;
  logic [7:0]  op_count = 0, in_data = 0;
  logic        in_ready, mac_en, res_valid, res_last, busy, done, err;
  logic [7:0]  mac_B1, mac_A0, mac_A1, mac_A2, mac_A3;
  logic [34:0] mac_cfg;
  int total = 0, bad = 0, cyc, n_en;
  logic [7:0] stream [16];
  int sp;

  typedef struct {
    logic [1:0]  m;
    logic        a;
    logic [31:0] iv;
    int          nw;
    logic [39:0] w;
    logic [7:0]  b1, a0, a1, a2, a3;
    int          lat;
  } vec_t;
  vec_t vecs [5];

  mac_operand_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .acc_sel(acc_sel),
    .init_val(init_val), .op_count(op_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mac_en(mac_en), .mac_B1(mac_B1), .mac_A0(mac_A0),
    .mac_A1(mac_A1), .mac_A2(mac_A2), .mac_A3(mac_A3), .mac_cfg(mac_cfg),
    .res_valid(res_valid), .res_last(res_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [39:0] w, input int n);
    for (int j = 0; j < n; j++) stream[j] = w[39-8*j -: 8];
    sp = 0;
  endtask

  task automatic start_job(input logic [1:0] m, input logic a, input logic [31:0] iv, input logic [7:0] n);
    start = 1; mode = m; acc_sel = a; init_val = iv; op_count = n;
    tick;
    start = 0;
  endtask

  // Feeds the stream (optionally valid every other cycle) until mac_en, bounded
  task automatic run_to_en(input bit toggle, output int c);
    logic go;
    c = 0;
    do begin
      in_valid = toggle ? (c % 2 == 0) : 1'b1;
      in_data  = in_valid ? stream[sp & 15] : 8'hEE;
      go = in_valid && in_ready;
      tick;
      if (go) sp++;
      c++;
    end while (!mac_en && c < 40);
    in_valid = 0;
  endtask

  task automatic chk_ops(input string tag, input logic [39:0] exp);
    chk({tag, "_B1"}, mac_B1, exp[39:32]);
    chk({tag, "_A0"}, mac_A0, exp[31:24]);
    chk({tag, "_A1"}, mac_A1, exp[23:16]);
    chk({tag, "_A2"}, mac_A2, exp[15:8]);
    chk({tag, "_A3"}, mac_A3, exp[7:0]);
  endtask

  task automatic chk_end(input string tag);
    tick;
    chk({tag, "_res"}, {res_valid, res_last, done, mac_en, busy}, 5'b11100);
  endtask

  initial begin
    vecs[0] = '{2'b10, 1'b1, 32'hDEADBEEF, 5, 40'h0211223344, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 6};
    vecs[1] = '{2'b00, 1'b0, 32'd7,        2, 40'hAA55000000, 8'hAA, 8'h00, 8'h55, 8'h00, 8'h00, 3};
    vecs[2] = '{2'b01, 1'b1, 32'h1234,     3, 40'h0102030000, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 4};
    vecs[3] = '{2'b10, 1'b0, 32'd0,        5, 40'hF0E1D2C3B4, 8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 6};
    vecs[4] = '{2'b00, 1'b1, 32'd5,        2, 40'h0304000000, 8'h03, 8'h00, 8'h04, 8'h00, 8'h00, 3};

    tick; tick;
    chk("rst_ctrl", {in_ready, mac_en, res_valid, res_last, busy, done, err}, 0);
    chk("rst_ops", {mac_B1, mac_A0, mac_A1, mac_A2, mac_A3}, 0);
    chk("rst_cfg", mac_cfg, 0);
    rst = 1;
    tick;

    foreach (vecs[i]) begin
      load(vecs[i].w, vecs[i].nw);
      start_job(vecs[i].m, vecs[i].a, vecs[i].iv, 8'd1);
      chk($sformatf("v%0d_start", i), {busy, in_ready}, 2'b11);
      run_to_en(0, cyc);
      chk($sformatf("v%0d_lat", i), cyc + 1, vecs[i].lat);
      chk_ops($sformatf("v%0d", i), {vecs[i].b1, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].a3});
      chk($sformatf("v%0d_cfg", i), mac_cfg, {vecs[i].iv, vecs[i].a, vecs[i].m});
      chk_end($sformatf("v%0d", i));
    end

    load(40'h0304060700, 4);
    start_job(2'b00, 1'b1, 32'd5, 8'd2);
    run_to_en(0, cyc);
    chk("s2_lat", cyc + 1, 3);
    chk_ops("s2_op1", 40'h0300040000);
    tick;
    chk("s2_mid", {res_valid, res_last, done, busy}, 4'b1001);
    run_to_en(0, cyc);
    chk("s2_gap", cyc + 1, 3);
    chk_ops("s2_op2", 40'h0600070000);
    chk("s2_cfg", mac_cfg, {32'd5, 1'b1, 2'b00});
    chk_end("s2");

    start_job(2'b11, 1'b0, 32'd99, 8'd1);
    chk("rsv_pulse", {err, busy, in_ready, done}, 4'b1000);
    chk("rsv_cfg", mac_cfg, {32'd5, 1'b1, 2'b00});
    tick;
    chk("rsv_clear", {err, busy}, 2'b00);

    start_job(2'b00, 1'b0, 32'd0, 8'd0);
    chk("zero_pulse", {done, busy, in_ready, mac_en, err}, 5'b10000);
    tick;
    chk("zero_clear", {done, busy, mac_en}, 3'b000);

    load(40'h0901020000, 3);
    start_job(2'b01, 1'b0, 32'h77, 8'd1);
    run_to_en(1, cyc);
    chk("bp_lat", cyc, 5);
    chk_ops("bp", 40'h0901020000);
    chk_end("bp");
    n_en = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (mac_en) n_en++;
    end
    chk("bp_no_extra_en", n_en, 0);

    load(40'h0211223344, 5);
    start_job(2'b10, 1'b1, 32'hCAFE, 8'd1);
    in_valid = 1; in_data = stream[0];
    tick;
    start = 1; mode = 2'b01; init_val = 32'h1111; in_data = stream[1];
    tick;
    start = 0; sp = 2;
    chk("busy_start_err", err, 0);
    chk("busy_start_cfg", mac_cfg, {32'hCAFE, 1'b1, 2'b10});
    run_to_en(0, cyc);
    chk("busy_start_lat", cyc, 3);
    chk_ops("busy_start", 40'h0211223344);
    chk_end("busy_start");

    load(40'h5A00000000, 1);
    start_job(2'b10, 1'b0, 32'h42, 8'd1);
    in_valid = 1; in_data = 8'h5A;
    tick;
    rst = 0; in_valid = 0;
    tick;
    chk("mid_rst_ctrl", {in_ready, mac_en, res_valid, res_last, busy, done, err}, 0);
    chk("mid_rst_ops", {mac_B1, mac_A0, mac_A1, mac_A2, mac_A3}, 0);
    chk("mid_rst_cfg", mac_cfg, 0);
    rst = 1;
    load(40'h0506070000, 3);
    start_job(2'b01, 1'b1, 32'd8, 8'd1);
    chk("post_rst_start", {busy, in_ready}, 2'b11);
    run_to_en(0, cyc);
    chk("post_rst_lat", cyc + 1, 4);
    chk_ops("post_rst", 40'h0506070000);
    chk_end("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
